// File: rtl/aes_ks128_seq_if.sv
// Bundle of the key-expansion engine's control, SubWord request/grant and round-key stream.
// The engine takes the slave modport; its environment (tests, AES unit, key file) takes the master modport.
interface aes_ks128_seq_if;
  logic         start;
  logic [127:0] key;
  logic         busy;
  logic         sw_req;
  logic         sw_gnt;
  logic [31:0]  sw_in;
  logic [31:0]  sw_out;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         done;

  modport master (
    output start, key, sw_gnt, sw_out, rk_ready,
    input  busy, sw_req, sw_in, rk_valid, rk, rk_idx, done
  );

  modport slave (
    input  start, key, sw_gnt, sw_out, rk_ready,
    output busy, sw_req, sw_in, rk_valid, rk, rk_idx, done
  );
endinterface

// File: rtl/aes_ks128_seq.sv
// Sequential AES-128 key expansion: one round key per OUT/SUB pair, borrowing the
// shared AES unit's SubBytes path through a request/grant port.
module aes_ks128_seq (
  input  logic           clk,
  input  logic           rst,
  aes_ks128_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    SUB  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'd10;

  state_e      state_q, state_d;
  logic [31:0] w0_q, w1_q, w2_q, w3_q;
  logic [31:0] w0_d, w1_d, w2_d, w3_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;

  logic [31:0] rot_w3;
  logic [31:0] t_word;
  logic [31:0] n0, n1, n2, n3;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // The chained XOR is the whole round: each new word depends on the previous new word.
  assign rot_w3 = {w3_q[23:0], w3_q[31:24]};
  assign t_word = bus.sw_out ^ {rcon_q, 24'h0};
  assign n0     = w0_q ^ t_word;
  assign n1     = w1_q ^ n0;
  assign n2     = w2_q ^ n1;
  assign n3     = w3_q ^ n2;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would let later registers see updated ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w0_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      w3_q    <= '0;
      rcon_q  <= 8'h01;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      w3_q    <= w3_d;
      rcon_q  <= rcon_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path through the
  // case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    w3_d    = w3_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          w0_d    = bus.key[127:96];
          w1_d    = bus.key[95:64];
          w2_d    = bus.key[63:32];
          w3_d    = bus.key[31:0];
          rcon_d  = 8'h01;
          idx_d   = 4'd0;
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: begin
        // Without a grant sw_out is someone else's result, so nothing moves.
        if (bus.sw_gnt) begin
          w0_d    = n0;
          w1_d    = n1;
          w2_d    = n2;
          w3_d    = n3;
          rcon_d  = xtime(rcon_q);
          idx_d   = idx_q + 4'd1;
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign bus.busy     = (state_q != IDLE);
  assign bus.sw_req   = (state_q == SUB);
  assign bus.sw_in    = bus.sw_req ? rot_w3 : 32'h0;
  assign bus.rk_valid = (state_q == OUT);
  assign bus.rk       = bus.rk_valid ? {w0_q, w1_q, w2_q, w3_q} : 128'h0;
  assign bus.rk_idx   = bus.rk_valid ? idx_q : 4'd0;
  assign bus.done     = done_q;

  a_rk_hold : assert property (@(posedge clk) disable iff (rst)
    bus.rk_valid && !bus.rk_ready |=> bus.rk_valid && $stable(bus.rk) && $stable(bus.rk_idx));

  a_idx_range : assert property (@(posedge clk) disable iff (rst) idx_q <= LAST_IDX);

  a_done_idle : assert property (@(posedge clk) disable iff (rst) done_q |-> !bus.busy);

endmodule

// File: tb/tb_aes_ks128_seq.sv
// Directed bench for aes_ks128_seq: FIPS-197 and all-zero keys, backpressure, grant
// stalls, start-while-busy and mid-run reset, with a bench-side S-box on sw_out.
module tb_aes_ks128_seq;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;

  logic [7:0] sbox_t [256];

  localparam logic [127:0] KEY_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_ks128_seq_if bus ();

  aes_ks128_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done) n_done <= n_done + 1;

  // The shared AES unit's SubWord path, modelled combinationally.
  always_comb bus.sw_out = {sbox_t[bus.sw_in[31:24]], sbox_t[bus.sw_in[23:16]],
                            sbox_t[bus.sw_in[15:8]],  sbox_t[bus.sw_in[7:0]]};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                  {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // One expansion run, entered and left just after a rising edge with the DUT idle.
  task automatic expand(input logic [127:0] k, input int stall, input int bp_idx,
                        input int poke_idx, input int abort_idx, input bit has_hand,
                        input logic [127:0] hand1, input logic [127:0] hand10,
                        input logic [31:0] hand_sw0, input string tag);
    logic [127:0] exp_rk [11];
    logic [31:0]  w0, w1, w2, w3, t;
    logic [7:0]   rc;
    int t0, cur, st_cnt, bp_cnt, budget, nd0, exp_done;
    bit fin;

    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0]; rc = 8'h01;
    exp_rk[0] = k;
    for (int r = 1; r <= 10; r++) begin
      t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]} ^ {rc, 24'h0};
      w0 ^= t; w1 ^= w0; w2 ^= w1; w3 ^= w2;
      exp_rk[r] = {w0, w1, w2, w3};
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
    end

    check({tag, ":idle_busy"}, bus.busy, 1'b0);
    bus.key = k; bus.start = 1'b1; bus.rk_ready = 1'b1; bus.sw_gnt = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    nd0 = n_done;
    check({tag, ":busy_n1"}, bus.busy, 1'b1);
    check({tag, ":valid_n1"}, bus.rk_valid, 1'b1);

    cur = 0; st_cnt = 0; bp_cnt = 0; budget = 0; fin = 1'b0;
    while (!fin) begin
      bus.start = 1'b0;
      bus.key   = ~k;
      if (bus.rk_valid) begin
        check($sformatf("%s:rk_idx%0d", tag, cur), bus.rk_idx, cur[3:0]);
        check($sformatf("%s:rk%0d", tag, cur), bus.rk, exp_rk[cur]);
        if (has_hand && cur == 1 && bp_cnt == 0) check({tag, ":rk1_vec"}, bus.rk, hand1);
        if (has_hand && cur == 10) check({tag, ":rk10_vec"}, bus.rk, hand10);
        if (cur == bp_idx && bp_cnt < 5) begin
          bus.rk_ready = 1'b0;
          bp_cnt++;
          check($sformatf("%s:bp_no_req%0d", tag, bp_cnt), bus.sw_req, 1'b0);
        end else begin
          bus.rk_ready = 1'b1;
          if (cur == poke_idx) begin
            bus.start = 1'b1;
            bus.key   = k ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
          end
          if (cur == 10) fin = 1'b1;
        end
      end else if (bus.sw_req) begin
        check($sformatf("%s:sw_in%0d", tag, cur), bus.sw_in, rot_word(exp_rk[cur][31:0]));
        if (has_hand && cur == 0 && st_cnt == 0) check({tag, ":sw_in_first"}, bus.sw_in, hand_sw0);
        if (cur == abort_idx) begin
          rst = 1'b1;
          #1;
          check({tag, ":rst_busy"}, bus.busy, 1'b0);
          check({tag, ":rst_sw_req"}, bus.sw_req, 1'b0);
          check({tag, ":rst_sw_in"}, bus.sw_in, 32'h0);
          check({tag, ":rst_valid"}, bus.rk_valid, 1'b0);
          check({tag, ":rst_rk"}, bus.rk, 128'h0);
          check({tag, ":rst_rk_idx"}, bus.rk_idx, 4'd0);
          check({tag, ":rst_done"}, bus.done, 1'b0);
          @(posedge clk); #1;
          rst = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          check({tag, ":after_rst_idle"}, bus.busy, 1'b0);
          check({tag, ":no_done"}, n_done, nd0);
          return;
        end
        if (st_cnt < stall) begin
          bus.sw_gnt = 1'b0;
          st_cnt++;
        end else begin
          bus.sw_gnt = 1'b1;
          st_cnt = 0;
          cur++;
        end
      end else begin
        check({tag, ":unexpected_idle"}, bus.busy, 1'b1);
        return;
      end
      budget++;
      if (budget > 600) begin
        check({tag, ":timeout"}, 1'b1, 1'b0);
        return;
      end
      @(posedge clk); #1;
    end

    exp_done = t0 + 22 + 10 * stall + ((bp_idx >= 0) ? 5 : 0);
    check({tag, ":done"}, bus.done, 1'b1);
    check({tag, ":done_busy"}, bus.busy, 1'b0);
    check({tag, ":done_cycle"}, cyc, exp_done);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key = '0;
    bus.rk_ready = 1'b0;
    bus.sw_gnt = 1'b0;
    build_sbox();
    #3;
    check("reset:busy", bus.busy, 1'b0);
    check("reset:sw_req", bus.sw_req, 1'b0);
    check("reset:sw_in", bus.sw_in, 32'h0);
    check("reset:rk_valid", bus.rk_valid, 1'b0);
    check("reset:rk", bus.rk, 128'h0);
    check("reset:rk_idx", bus.rk_idx, 4'd0);
    check("reset:done", bus.done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    expand(KEY_FIPS, 0, -1, -1, -1, 1'b1, FIPS_RK1, FIPS_RK10, 32'hcf4f3c09, "fips");
    // Chained directly: this start lands in the cycle where done is high.
    expand(128'h0, 0, -1, -1, -1, 1'b1, ZERO_RK1, ZERO_RK10, 32'h0, "zero");
    expand(KEY_FIPS, 0, 3, -1, -1, 1'b1, FIPS_RK1, FIPS_RK10, 32'hcf4f3c09, "backpressure");
    expand(KEY_FIPS, 3, -1, -1, -1, 1'b1, FIPS_RK1, FIPS_RK10, 32'hcf4f3c09, "gnt_stall");
    expand(KEY_FIPS, 0, -1, 5, -1, 1'b1, FIPS_RK1, FIPS_RK10, 32'hcf4f3c09, "start_busy");
    @(posedge clk); #1;
    expand(KEY_FIPS, 0, -1, -1, 7, 1'b0, '0, '0, '0, "abort");
    expand(KEY_FIPS, 0, -1, -1, -1, 1'b1, FIPS_RK1, FIPS_RK10, 32'hcf4f3c09, "fresh");

    @(posedge clk); #1;
    check("done_pulses", n_done, 6);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_ks128_seq.md
# aes_ks128_seq

Sequential AES-128 key-expansion engine that sits upstream of the shared AES instruction unit. It time-shares that unit's SubBytes path (sub=1 mode) through a request/grant port, so it adds no S-boxes of its own. It produces the 11 round keys one at a time on a valid/ready stream that feeds the round-key register file used by the sbsr/mix instructions.

## Interface

Parameters: none. The key length is fixed at 128 bits and the round count at 10.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: start expansion; sampled only in IDLE.
- `key` in 128: cipher key. Word w0 = key[127:96], w3 = key[31:0]. Byte 0 of each word is at [31:24].
- `busy` out 1: high in every state except IDLE.
- `sw_req` out 1: request for the shared unit's SubWord path.
- `sw_gnt` in 1: grant. When high in the same cycle as `sw_req`, the unit is driven with a=`sw_in`, sub=1.
- `sw_in` out 32: RotWord(w3) = {w3[23:0], w3[31:24]}; zero when `sw_req`=0.
- `sw_out` in 32: combinational SubWord result, returned in the same cycle.
- `rk_valid` out 1: round key available.
- `rk_ready` in 1: consumer accepts the round key.
- `rk` out 128: round key {w0,w1,w2,w3}.
- `rk_idx` out 4: round number 0..10 of `rk`.
- `done` out 1: one-cycle pulse after round key 10 is accepted.

## Operation

- Internal state:
  - w0..w3: 32 bits each.
  - rcon: 8 bits.
  - idx: 4 bits.
  - FSM states: IDLE, OUT, SUB.
- IDLE:
  - `start`=1 loads w0..w3 from `key`, sets rcon=0x01 and idx=0, then goes to OUT.
- OUT:
  - `rk_valid`=1, `rk`={w0..w3}, `rk_idx`=idx.
  - On `rk_valid`&`rk_ready`: if idx==10, go to IDLE and pulse `done` in the following cycle. Otherwise go to SUB.
- SUB:
  - `sw_req`=1 and `sw_in`=RotWord(w3).
  - While `sw_gnt`=0, hold in SUB with all registers unchanged.
  - On `sw_gnt`=1, compute t = `sw_out` ^ {rcon,24'h0}, then at the edge:
    - w0' = w0^t
    - w1' = w1^w0'
    - w2' = w2^w1'
    - w3' = w3^w2'
    - rcon' = xtime(rcon), where xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00)
    - idx' = idx+1
    - go to OUT.
- The rcon sequence seen across SUB states is 01,02,04,08,10,20,40,80,1b,36. It is never used beyond 0x36.
- `start` is ignored while `busy`=1, with no effect on state.
- `key` is sampled only on the accepting `start` edge. Later changes to `key` have no effect on the run in progress.

## Timing

- Reset values:
  - FSM=IDLE.
  - `busy`=0, `sw_req`=0, `sw_in`=0, `rk_valid`=0, `rk`=0, `rk_idx`=0, `done`=0.
  - rcon=0x01.
- `start` in cycle N gives `busy`=1 and `rk_valid`=1 with round key 0 in cycle N+1.
- Each subsequent round takes 1 SUB cycle plus any grant stall, plus at least 1 OUT cycle.
- Minimum total with `rk_ready` and `sw_gnt` tied high:
  - 21 cycles from `start` to acceptance of round key 10.
  - `done` in cycle N+22, with `busy`=0 in that same cycle.
- `rk` and `rk_idx` stay stable while `rk_valid`=1 and `rk_ready`=0.
- `rk_valid` never drops without a handshake.
- `sw_in` changes only on a state transition.
- The SubWord path is combinational through the external unit. `sw_out` is consumed in the same cycle as the grant; no extra pipeline stage.
- A new `start` is accepted in the same cycle that `done` is high, because the FSM is already in IDLE.
- `rst` asserted in any state, including mid-stall, returns to reset values immediately. No `done` pulse is issued for the aborted run.

## Test plan

- **FIPS-197 key:** key=2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=`sw_gnt`=1, bench S-box model on `sw_out`.
  - Required: rk0=key, rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: `done` at N+22.
- **All-zero key:**
  - Required: rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
  - Required: `sw_in`=00000000 in the first SUB cycle.
- **Backpressure:** hold `rk_ready`=0 for 5 cycles at idx=3 → `rk` and `rk_idx` unchanged throughout, no `sw_req` raised, and the final keys match the first test.
- **Grant stall:** hold `sw_gnt`=0 for 3 cycles in every SUB → `sw_req` held high with `sw_in` stable, final keys unchanged, and `done` delayed by exactly 30 cycles.
- **Start while busy:** pulse `start` with a different key at idx=5 → ignored, and the sequence completes for the original key.
- **Reset mid-run:** assert `rst` in SUB at idx=7 → all outputs return to reset values in the same cycle and `done` never pulses. A fresh `start` then reproduces the first test.
